// File: rtl/ft245r_bus_arbiter.sv
// FT245R bus owner: shares the parallel bus between host reads and writes.
// Define FT245R_ARB_RXPRIO_EN for fixed RX priority (default round-robin).
module ft245r_bus_arbiter #(
    parameter int RD_LOW_CYC   = 3,
    parameter int RD_HIGH_CYC  = 4,
    parameter int WR_SETUP_CYC = 1,
    parameter int WR_HIGH_CYC  = 3,
    parameter int WR_GAP_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxf_,
    input  logic       txe_,
    input  logic [7:0] usb_din,
    output logic       rd_,
    output logic       wr,
    output logic [7:0] usb_dout,
    output logic       usb_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LOW,
        S_RD_HIGH,
        S_WR_SETUP,
        S_WR_HIGH,
        S_WR_GAP
    } state_t;

    localparam logic [3:0] RD_LOW_LD   = 4'(RD_LOW_CYC - 1);
    localparam logic [3:0] RD_HIGH_LD  = 4'(RD_HIGH_CYC - 1);
    localparam logic [3:0] WR_SETUP_LD = 4'(WR_SETUP_CYC - 1);
    localparam logic [3:0] WR_HIGH_LD  = 4'(WR_HIGH_CYC - 1);
    localparam logic [3:0] WR_GAP_LD   = 4'(WR_GAP_CYC - 1);

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;

    logic       rxf_m;
    logic       rxf_s;
    logic       txe_m;
    logic       txe_s;

    logic       tx_full;
    logic [7:0] tx_hold;
    logic [7:0] dout_q;

    logic       rx_req;
    logic       tx_req;
    logic       grant_rx;
    logic       grant_tx;
    logic       rd_sample;
    logic       wr_done;
    logic       gap_first;

    // Two-flop synchronisers for the asynchronous FT245R status pins
    always_ff @(posedge clk) begin
        if (rst) begin
            rxf_m <= 1'b1;
            rxf_s <= 1'b1;
            txe_m <= 1'b1;
            txe_s <= 1'b1;
        end else begin
            rxf_m <= rxf_;
            rxf_s <= rxf_m;
            txe_m <= txe_;
            txe_s <= txe_m;
        end
    end

    // Requests are only meaningful while the bus is parked in IDLE
    always_comb begin
        rx_req = (state == S_IDLE) && !rxf_s && !rx_valid;
        tx_req = (state == S_IDLE) && tx_full && !txe_s;
    end

`ifdef FT245R_ARB_RXPRIO_EN

    // Fixed priority: a pending read always beats a pending write
    always_comb begin
        grant_rx = rx_req;
        grant_tx = tx_req && !rx_req;
    end

`else

    // High when the most recent grant went to TX
    logic last_grant;

    // Round-robin: on contention the side not served last wins
    always_comb begin
        grant_rx = rx_req && (!tx_req || last_grant);
        grant_tx = tx_req && !grant_rx;
    end

    // Remember which side was served most recently
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant_rx) begin
            last_grant <= 1'b0;
        end else if (grant_tx) begin
            last_grant <= 1'b1;
        end
    end

`endif

    // State and phase counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; the counter reloads on every state entry
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rd_sample = 1'b0;
        wr_done   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (grant_rx) begin
                    state_nx = S_RD_LOW;
                    cnt_nx   = RD_LOW_LD;
                end else if (grant_tx) begin
                    state_nx = S_WR_SETUP;
                    cnt_nx   = WR_SETUP_LD;
                end
            end
            S_RD_LOW: begin
                if (cnt == 4'd0) begin
                    rd_sample = 1'b1;
                    state_nx  = S_RD_HIGH;
                    cnt_nx    = RD_HIGH_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_RD_HIGH: begin
                if (cnt == 4'd0) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_WR_SETUP: begin
                if (cnt == 4'd0) begin
                    state_nx = S_WR_HIGH;
                    cnt_nx   = WR_HIGH_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_WR_HIGH: begin
                if (cnt == 4'd0) begin
                    wr_done  = 1'b1;
                    state_nx = S_WR_GAP;
                    cnt_nx   = WR_GAP_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_WR_GAP: begin
                if (cnt == 4'd0) begin
                    state_nx = S_IDLE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // TX holding register; freed as wr falls so the next byte can queue
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_full <= 1'b0;
            tx_hold <= 8'd0;
        end else if (wr_done) begin
            tx_full <= 1'b0;
        end else if (tx_valid && !tx_full) begin
            tx_full <= 1'b1;
            tx_hold <= tx_data;
        end
    end

    // Bus-side copy of the TX byte, so a new push cannot disturb the hold cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= 8'd0;
        end else if (grant_tx) begin
            dout_q <= tx_hold;
        end
    end

    // RX holding register; a read never starts while it is occupied
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data  <= 8'd0;
            rx_valid <= 1'b0;
        end else if (rd_sample) begin
            rx_data  <= usb_din;
            rx_valid <= 1'b1;
        end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    // Pin drive decoded from state so a reset edge releases the bus at once
    always_comb begin
        gap_first = (state == S_WR_GAP) && (cnt == WR_GAP_LD);
        rd_       = (state != S_RD_LOW);
        wr        = (state == S_WR_HIGH);
        usb_oe    = (state == S_WR_SETUP) ||
                    (state == S_WR_HIGH)  ||
                    gap_first;
        usb_dout  = usb_oe ? dout_q : 8'd0;
        busy      = (state != S_IDLE);
        tx_ready  = !tx_full;
    end

endmodule
